// File: rtl/bcd_pkg.sv
// Shared types and constants for the sequential BCD to binary converter.
// Holds the FSM state encoding, digit constants and result-width helper.
package bcd_pkg;

   typedef enum logic [1:0] {
      S_IDLE  = 2'd0,
      S_SHIFT = 2'd1,
      S_DONE  = 2'd2
   } state_e;

   localparam int DIG_W    = 4;
   localparam int DIG_MAX  = 9;
   localparam int CORR_THR = 8;
   localparam int CORR_OFS = 3;

   // Smallest width w with 2**w >= 10**digits
   function automatic int bin_width(input int digits);
      longint lim;
      int     w;
      lim = 1;
      for (int i = 0; i < digits; i++) lim = lim * 10;
      w = 0;
      for (int i = 62; i >= 0; i--) begin
         if ((longint'(1) << i) >= lim) w = i;
      end
      return w;
   endfunction

endpackage

// File: rtl/bcd_digit_corr.sv
// Per-digit correction step of the reverse double-dabble.
// A digit of 8 or more after the right shift is reduced by 3.
module bcd_digit_corr
   import bcd_pkg::*;
(
   input  logic [3:0] d_in,
   output logic [3:0] d_out
);

   // Subtract the offset from digits that reached the threshold
   always_comb begin
      d_out = d_in;
      if (d_in >= 4'(CORR_THR)) d_out = d_in - 4'(CORR_OFS);
   end

endmodule

// File: rtl/bcd_to_bin_seq.sv
// Sequential packed-BCD to binary converter (reverse double-dabble).
// One bit of the result is produced per SHIFT cycle.
module bcd_to_bin_seq
   import bcd_pkg::*;
#(
   parameter int DIGITS = 3
) (
   input  logic                            clk,
   input  logic                            rst_n,
   input  logic                            start,
   input  logic [4*DIGITS-1:0]             bcd_in,
   output logic                            busy,
   output logic                            done,
   output logic                            err,
   output logic [bin_width(DIGITS)-1:0]    bin_out
);

   localparam int BIN_W = bin_width(DIGITS);
   localparam int BCD_W = DIG_W * DIGITS;
   localparam int CNT_W = $clog2(BIN_W + 1);
   localparam int CAT_W = BCD_W + BIN_W;

   state_e             state_q, state_d;
   logic [BCD_W-1:0]   bcd_q, bcd_d;
   logic [BIN_W-1:0]   acc_q, acc_d;
   logic [CNT_W-1:0]   cnt_q, cnt_d;
   logic [BIN_W-1:0]   bin_out_q, bin_out_d;
   logic               err_q, err_d;

   logic [CAT_W-1:0]   cat_sh;
   logic [BCD_W-1:0]   bcd_sh;
   logic [BIN_W-1:0]   acc_sh;
   logic [BCD_W-1:0]   bcd_corr;
   logic               bad_digit;

   // Right shift of the {bcd, result} pair
   always_comb begin
      cat_sh = {bcd_q, acc_q} >> 1;
      bcd_sh = cat_sh[CAT_W-1:BIN_W];
      acc_sh = cat_sh[BIN_W-1:0];
   end

   for (genvar g = 0; g < DIGITS; g++) begin : g_corr
      bcd_digit_corr u_corr (
         .d_in  (bcd_sh[g*DIG_W +: DIG_W]),
         .d_out (bcd_corr[g*DIG_W +: DIG_W])
      );
   end

   // Flag any incoming digit above 9
   always_comb begin
      bad_digit = 1'b0;
      for (int i = 0; i < DIGITS; i++) begin
         if (bcd_in[i*DIG_W +: DIG_W] > 4'(DIG_MAX)) bad_digit = 1'b1;
      end
   end

   // Next-state, datapath and output decode
   always_comb begin
      state_d   = state_q;
      bcd_d     = bcd_q;
      acc_d     = acc_q;
      cnt_d     = cnt_q;
      bin_out_d = bin_out_q;
      err_d     = err_q;
      busy      = 1'b0;
      done      = 1'b0;
      unique case (state_q)
         S_IDLE: begin
            if (start) begin
               bcd_d = bcd_in;
               acc_d = '0;
               cnt_d = '0;
               if (bad_digit) begin
                  state_d   = S_DONE;
                  err_d     = 1'b1;
                  bin_out_d = '0;
               end else begin
                  state_d = S_SHIFT;
               end
            end
         end
         S_SHIFT: begin
            busy  = 1'b1;
            bcd_d = bcd_corr;
            acc_d = acc_sh;
            cnt_d = cnt_q + 1'b1;
            if (cnt_q == CNT_W'(BIN_W - 1)) begin
               state_d   = S_DONE;
               bin_out_d = acc_sh;
               err_d     = 1'b0;
            end
         end
         S_DONE: begin
            done    = 1'b1;
            state_d = S_IDLE;
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   // State and datapath registers
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state_q   <= S_IDLE;
         bcd_q     <= '0;
         acc_q     <= '0;
         cnt_q     <= '0;
         bin_out_q <= '0;
         err_q     <= 1'b0;
      end else begin
         state_q   <= state_d;
         bcd_q     <= bcd_d;
         acc_q     <= acc_d;
         cnt_q     <= cnt_d;
         bin_out_q <= bin_out_d;
         err_q     <= err_d;
      end
   end

   assign bin_out = bin_out_q;
   assign err     = err_q;

endmodule
